matrix_scan: RTL and testbench

MATRIX_SCAN -- requirements
Module: matrix_scan

---
 rtl/matrix_pkg.sv | 17 +
 rtl/bcm_timer.sv | 29 ++
 rtl/matrix_scan.sv | 187 ++++++++++++++++++
 tb/tb_matrix_scan.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix scanner: FSM state encoding and
// default geometry/timing parameters.
package matrix_pkg;

  localparam int unsigned DEF_COLS         = 64;
  localparam int unsigned DEF_ROWS         = 16;
  localparam int unsigned DEF_BITS         = 6;
  localparam int unsigned DEF_DISPLAY_BASE = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } scan_state_e;

endpackage

// File: rtl/bcm_timer.sv
// Loadable down-counter timing the binary-coded-modulation display window.
// After a load of N, done is low for N-1 cycles and high on the N-th.
module bcm_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value - W'(1);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/matrix_scan.sv
// HUB75-style panel scanner: shifts one row pair per brightness plane, latches
// it, then enables the LEDs for a plane-weighted number of cycles.
module matrix_scan
  import matrix_pkg::*;
#(
  parameter int unsigned COLS         = DEF_COLS,
  parameter int unsigned ROWS         = DEF_ROWS,
  parameter int unsigned BITS         = DEF_BITS,
  parameter int unsigned DISPLAY_BASE = DEF_DISPLAY_BASE
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [2:0]                           rgb_top,
  input  logic [2:0]                           rgb_bottom,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0] pixel_addr,
  output logic [BITS-1:0]                      brightness_mask,
  output logic [2:0]                           matrix_rgb_top,
  output logic [2:0]                           matrix_rgb_bottom,
  output logic                                 matrix_clk,
  output logic                                 matrix_latch,
  output logic                                 matrix_oe_n,
  output logic [$clog2(ROWS)-1:0]              matrix_row,
  output logic                                 frame_done
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int PIX_W = ROW_W + COL_W;
  localparam int CNT_W = COL_W + 1;
  localparam int BIT_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int TMR_W = $clog2(DISPLAY_BASE << (BITS - 1)) + 1;

  // Slot COLS is the extra slot that pushes the final column into the panel.
  localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(COLS);
  localparam logic [BIT_W-1:0] LAST_PLANE = BIT_W'(BITS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);

  scan_state_e      state, state_n;
  logic [CNT_W-1:0] col, col_n, col_inc;
  logic             phase, phase_n;
  logic [BIT_W-1:0] bit_idx, bit_n, bit_inc;
  logic [ROW_W-1:0] row, row_n;

  logic [PIX_W-1:0] addr_n;
  logic [BITS-1:0]  mask_n;
  logic [2:0]       rgb_top_n, rgb_bottom_n;
  logic             mclk_n, latch_n, oe_n_n, frame_done_n;
  logic [ROW_W-1:0] mrow_n;

  logic             timer_load, timer_done;
  logic [TMR_W-1:0] timer_value;

  assign col_inc     = col + CNT_W'(1);
  assign bit_inc     = bit_idx + BIT_W'(1);
  assign timer_value = TMR_W'(DISPLAY_BASE) << bit_idx;

  bcm_timer #(
    .W(TMR_W)
  ) u_bcm_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .done      (timer_done)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n      = state;
    col_n        = col;
    phase_n      = phase;
    bit_n        = bit_idx;
    row_n        = row;
    addr_n       = pixel_addr;
    mask_n       = brightness_mask;
    rgb_top_n    = matrix_rgb_top;
    rgb_bottom_n = matrix_rgb_bottom;
    mrow_n       = matrix_row;
    mclk_n       = 1'b0;
    latch_n      = 1'b0;
    oe_n_n       = 1'b1;
    frame_done_n = 1'b0;
    timer_load   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (enable) begin
          state_n = ST_SHIFT;
          col_n   = '0;
          phase_n = 1'b0;
          addr_n  = {row, COL_W'(0)};
        end
      end

      ST_SHIFT: begin
        if (!phase) begin
          phase_n = 1'b1;
          mclk_n  = 1'b1;
        end else begin
          phase_n = 1'b0;
          // RAM data for this slot's address arrives during phase B.
          if (col != LAST_SLOT) begin
            rgb_top_n    = rgb_top;
            rgb_bottom_n = rgb_bottom;
          end
          if (col == LAST_SLOT) begin
            state_n = ST_LATCH;
            latch_n = 1'b1;
            mrow_n  = row;
          end else begin
            col_n = col_inc;
            if (col_inc != LAST_SLOT) begin
              addr_n = {row, col_inc[COL_W-1:0]};
            end
          end
        end
      end

      ST_LATCH: begin
        state_n    = ST_DISPLAY;
        oe_n_n     = 1'b0;
        timer_load = 1'b1;
      end

      ST_DISPLAY: begin
        if (!timer_done) begin
          oe_n_n = 1'b0;
        end else if (bit_idx == LAST_PLANE) begin
          state_n      = ST_IDLE;
          bit_n        = '0;
          mask_n       = BITS'(1);
          row_n        = row + ROW_W'(1);
          frame_done_n = (row == LAST_ROW);
        end else begin
          state_n = ST_SHIFT;
          bit_n   = bit_inc;
          mask_n  = BITS'(1) << bit_inc;
          col_n   = '0;
          phase_n = 1'b0;
          addr_n  = {row, COL_W'(0)};
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Asynchronous reset blanks the panel immediately, even mid-display.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      col               <= '0;
      phase             <= 1'b0;
      bit_idx           <= '0;
      row               <= '0;
      pixel_addr        <= '0;
      brightness_mask   <= BITS'(1);
      matrix_rgb_top    <= '0;
      matrix_rgb_bottom <= '0;
      matrix_clk        <= 1'b0;
      matrix_latch      <= 1'b0;
      matrix_oe_n       <= 1'b1;
      matrix_row        <= '0;
      frame_done        <= 1'b0;
    end else begin
      state             <= state_n;
      col               <= col_n;
      phase             <= phase_n;
      bit_idx           <= bit_n;
      row               <= row_n;
      pixel_addr        <= addr_n;
      brightness_mask   <= mask_n;
      matrix_rgb_top    <= rgb_top_n;
      matrix_rgb_bottom <= rgb_bottom_n;
      matrix_clk        <= mclk_n;
      matrix_latch      <= latch_n;
      matrix_oe_n       <= oe_n_n;
      matrix_row        <= mrow_n;
      frame_done        <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_matrix_scan.sv
// Self-checking bench for matrix_scan on a 4x2 panel with 6 planes: plane
// timing table, panel shift-register scoreboard and multi-cycle corner cases.
module tb_matrix_scan;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int BITS = 6;
  localparam int DB   = 2;
  localparam int FRAME_CYCLES = 386;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] rgb_top, rgb_bottom;
  logic [2:0] pixel_addr;
  logic [5:0] brightness_mask;
  logic [2:0] matrix_rgb_top, matrix_rgb_bottom;
  logic       matrix_clk, matrix_latch, matrix_oe_n, frame_done;
  logic [0:0] matrix_row;

  matrix_scan #(
    .COLS(COLS), .ROWS(ROWS), .BITS(BITS), .DISPLAY_BASE(DB)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .rgb_top          (rgb_top),
    .rgb_bottom       (rgb_bottom),
    .pixel_addr       (pixel_addr),
    .brightness_mask  (brightness_mask),
    .matrix_rgb_top   (matrix_rgb_top),
    .matrix_rgb_bottom(matrix_rgb_bottom),
    .matrix_clk       (matrix_clk),
    .matrix_latch     (matrix_latch),
    .matrix_oe_n      (matrix_oe_n),
    .matrix_row       (matrix_row),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  // Frame buffer with one cycle of read latency: top carries the column
  // index, bottom carries {row, column}.
  logic [2:0] ram_q = 3'd0;
  always @(posedge clk) ram_q <= pixel_addr;
  assign rgb_top    = {1'b0, ram_q[1:0]};
  assign rgb_bottom = ram_q;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, "_oe_n"}, 32'(matrix_oe_n), 32'd1);
    check({name, "_all"},
          32'({pixel_addr, brightness_mask, matrix_rgb_top, matrix_rgb_bottom,
               matrix_clk, matrix_latch, matrix_oe_n, matrix_row, frame_done}),
          32'({3'd0, 6'b000001, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
  endtask

  // Scoreboard: one entry per expected latch pulse.
  typedef struct {
    int         row;
    logic [5:0] mask;
    logic [11:0] top;
    logic [11:0] bot;
  } sb_t;
  sb_t exp_q[$];

  task automatic push_row(input int r, input int planes);
    sb_t e;
    for (int p = 0; p < planes; p++) begin
      e.row  = r;
      e.mask = 6'b000001 << p;
      e.top  = '0;
      e.bot  = '0;
      for (int c = 0; c < COLS; c++) begin
        e.top = {e.top[8:0], 3'(c)};
        e.bot = {e.bot[8:0], 1'(r), 2'(c)};
      end
      exp_q.push_back(e);
    end
  endtask

  // Panel model and invariant monitor, sampled on the falling edge.
  logic [11:0] sh_top = '0, sh_bot = '0;
  logic        prev_mclk = 1'b0;
  logic [2:0]  prev_top = '0, prev_bot = '0;
  logic [5:0]  prev_mask = 6'b000001;
  int cyc = 0, fd_count = 0, fd_last = 0, fd_width = 0;

  always @(negedge clk) begin
    sb_t e;
    cyc++;
    check("mask_onehot", 32'($onehot(brightness_mask)), 32'd1);
    check("latch_with_oe", 32'(matrix_latch & ~matrix_oe_n), 32'd0);
    if (matrix_clk && !prev_mclk) begin
      check("rgb_top_setup", 32'(matrix_rgb_top), 32'(prev_top));
      check("rgb_bot_setup", 32'(matrix_rgb_bottom), 32'(prev_bot));
      check("mask_in_shift", 32'(brightness_mask), 32'(prev_mask));
      sh_top = {sh_top[8:0], matrix_rgb_top};
      sh_bot = {sh_bot[8:0], matrix_rgb_bottom};
    end
    if (matrix_latch) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_row", 32'(matrix_row), 32'(e.row));
        check("sb_mask", 32'(brightness_mask), 32'(e.mask));
        check("sb_top", 32'(sh_top), 32'(e.top));
        check("sb_bottom", 32'(sh_bot), 32'(e.bot));
      end
    end
    if (frame_done) begin
      if (fd_width == 0) begin
        if (fd_count > 0) check("frame_period", 32'(cyc - fd_last), 32'(FRAME_CYCLES));
        fd_count++;
        fd_last = cyc;
      end
      fd_width++;
    end else if (fd_width > 0) begin
      check("frame_done_width", 32'(fd_width), 32'd1);
      fd_width = 0;
    end
    prev_mclk = matrix_clk;
    prev_top  = matrix_rgb_top;
    prev_bot  = matrix_rgb_bottom;
    prev_mask = brightness_mask;
  end

  // Walks one plane from its first SHIFT sample through the end of DISPLAY,
  // returning on the first sample with oe_n high again.
  task automatic measure_plane(input int row, output int pre, output int pulses,
                               output int lat, output int oe_low,
                               output logic [5:0] mask0, output logic stable);
    logic pm;
    logic [2:0] ea;
    int slot;
    pre = 0; pulses = 0; lat = 0; oe_low = 0; pm = 1'b0; stable = 1'b1;
    mask0 = brightness_mask;
    while (!matrix_latch && pre < 200) begin
      slot = (pre / 2 < COLS) ? pre / 2 : COLS - 1;
      ea = {1'(row), 2'(slot)};
      if (pre < 2 * (COLS + 1)) check("pixel_addr", 32'(pixel_addr), 32'(ea));
      if (brightness_mask !== mask0) stable = 1'b0;
      if (matrix_clk && !pm) pulses++;
      pm = matrix_clk;
      pre++;
      @(negedge clk);
    end
    while (matrix_latch && lat < 10) begin
      lat++;
      @(negedge clk);
    end
    while (!matrix_oe_n && oe_low < 300) begin
      oe_low++;
      @(negedge clk);
    end
  endtask

  task automatic quiet_window(input string name, input int cycles);
    int pulses, oe_lo, lat;
    logic pm;
    pulses = 0; oe_lo = 0; lat = 0; pm = matrix_clk;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (matrix_clk && !pm) pulses++;
      pm = matrix_clk;
      if (!matrix_oe_n) oe_lo++;
      if (matrix_latch) lat++;
    end
    check({name, "_clk_pulses"}, 32'(pulses), 32'd0);
    check({name, "_oe_low"}, 32'(oe_lo), 32'd0);
    check({name, "_latches"}, 32'(lat), 32'd0);
  endtask

  typedef struct {
    int         pre;
    int         pulses;
    int         lat;
    int         oe_low;
    logic [5:0] mask;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int pre, pul, lat, oe;
    logic [5:0] m;
    logic st;

    tbl[0] = '{10, 5, 1,  2, 6'b000001};
    tbl[1] = '{10, 5, 1,  4, 6'b000010};
    tbl[2] = '{10, 5, 1,  8, 6'b000100};
    tbl[3] = '{10, 5, 1, 16, 6'b001000};
    tbl[4] = '{10, 5, 1, 32, 6'b010000};
    tbl[5] = '{10, 5, 1, 64, 6'b100000};

    repeat (3) @(negedge clk);
    check_reset("reset_hold");
    #1 reset = 1'b0;
    quiet_window("idle_disabled", 100);
    check("idle_addr", 32'(pixel_addr), 32'd0);

    #1 enable = 1'b1;
    push_row(0, BITS);
    @(negedge clk);
    for (int p = 0; p < BITS; p++) begin
      measure_plane(0, pre, pul, lat, oe, m, st);
      check($sformatf("p%0d_shift_cycles", p), 32'(pre), 32'(tbl[p].pre));
      check($sformatf("p%0d_clk_pulses", p), 32'(pul), 32'(tbl[p].pulses));
      check($sformatf("p%0d_latch_cycles", p), 32'(lat), 32'(tbl[p].lat));
      check($sformatf("p%0d_oe_low", p), 32'(oe), 32'(tbl[p].oe_low));
      check($sformatf("p%0d_mask", p), 32'(m), 32'(tbl[p].mask));
      check($sformatf("p%0d_mask_stable", p), 32'(st), 32'd1);
    end
    check("row_end_oe_n", 32'(matrix_oe_n), 32'd1);

    // Finish frame 1 and run frame 2; matrix_row must go 0,1,0,1.
    push_row(1, BITS);
    push_row(0, BITS);
    push_row(1, BITS);
    for (int i = 0; i < 1500 && fd_count < 2; i++) @(negedge clk);
    check("two_frames", 32'(fd_count), 32'd2);
    check("frames_drained", 32'(exp_q.size()), 32'd0);

    // Dropping enable mid-row still lets that row finish every plane.
    push_row(0, BITS);
    repeat (30) @(negedge clk);
    #1 enable = 1'b0;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check("disable_row_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 100 && matrix_oe_n; i++) @(negedge clk);
    for (int i = 0; i < 100 && !matrix_oe_n; i++) @(negedge clk);
    quiet_window("idle_after_drop", 50);

    // Reset while plane 3 is on the panel.
    #1 enable = 1'b1;
    push_row(1, 4);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    for (int i = 0; i < 20 && matrix_oe_n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("pre_reset_in_display", 32'(matrix_oe_n), 32'd0);
    check("pre_reset_mask", 32'(brightness_mask), 32'(6'b001000));
    #1 reset = 1'b1;
    #1 check_reset("reset_async");
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_reset("reset_held");
    #1 reset = 1'b0;
    push_row(0, BITS);
    @(negedge clk);
    measure_plane(0, pre, pul, lat, oe, m, st);
    check("restart_shift_cycles", 32'(pre), 32'd10);
    check("restart_mask", 32'(m), 32'(6'b000001));
    check("restart_oe_low", 32'(oe), 32'd2);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check("restart_row_drained", 32'(exp_q.size()), 32'd0);
    check("frame_count", 32'(fd_count), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
